// File: rtl/z80_uart_tx_port.sv
// Z80 I/O-mapped UART transmitter. OUT cycles to BASE queue bytes into a small
// FIFO that is serialised as 8N1 frames on tx. IN from BASE+1 returns a status byte.
module z80_uart_tx_port #(
  parameter logic [7:0] BASE_ADDR    = 8'h10,
  parameter int         CLKS_PER_BIT = 234,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_din,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  output logic [7:0] io_dout,
  output logic       io_doe,
  output logic       tx,
  output logic       tx_busy
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  localparam logic [7:0]      CTRL_ADDR = BASE_ADDR + 8'd1;
  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic            io_wr, io_rd, wr_q;
  logic            wr_fire, push_req, ctrl_wr;
  logic            full, empty, push, pop;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [1:0]      state;
  logic [CNTW-1:0] clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_last;
  logic [2:0]      cnt_field;
  logic [7:0]      status;

  // Interrupt-acknowledge cycles (m1_n low) never count as I/O accesses.
  assign io_wr = !iorq_n && !wr_n && m1_n;
  assign io_rd = !iorq_n && !rd_n && m1_n;

  assign wr_fire  = io_wr && !wr_q;
  assign push_req = wr_fire && (io_addr == BASE_ADDR);
  assign ctrl_wr  = wr_fire && (io_addr == CTRL_ADDR);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = push_req && !full;
  assign pop   = (state == S_IDLE) && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_q <= io_wr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full)
        ovf <= 1'b1;
      else if (ctrl_wr && io_din[3])
        ovf <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_din;
  end

  assign bit_last = (clk_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg   <= mem[rd_ptr];
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          clk_cnt <= bit_last ? '0 : clk_cnt + 1'b1;
          if (bit_last) state <= S_DATA;
        end
        S_DATA: begin
          clk_cnt <= bit_last ? '0 : clk_cnt + 1'b1;
          if (bit_last) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          clk_cnt <= bit_last ? '0 : clk_cnt + 1'b1;
          if (bit_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // tx decodes the registered state, so an async reset forces it high at once.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign tx_busy = !empty || (state != S_IDLE);

  assign cnt_field = 3'(count);
  assign status    = {1'b0, cnt_field, ovf, (state == S_IDLE) && empty, empty, !full};

  assign io_doe  = io_rd && (io_addr == CTRL_ADDR);
  assign io_dout = io_doe ? status : 8'h00;

endmodule

// File: tb/tb_z80_uart_tx_port.sv
// Bench for z80_uart_tx_port: decode vectors, directed frame/overflow/reset
// sequences, and random bus traffic checked cycle-by-cycle against a queue model.
module tb_z80_uart_tx_port;

  localparam int         CPB   = 4;
  localparam int         DEPTH = 4;
  localparam logic [7:0] BASE  = 8'h10;
  localparam logic [7:0] CTRL  = 8'h11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] io_addr = 8'h00;
  logic [7:0] io_din = 8'h00;
  logic       iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [7:0] io_dout;
  logic       io_doe, tx, tx_busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  z80_uart_tx_port #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_addr(io_addr),
    .io_din (io_din),
    .iorq_n (iorq_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .m1_n   (m1_n),
    .io_dout(io_dout),
    .io_doe (io_doe),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky overflow, and the number of clock
  // edges left until the current frame ends (0 means the line is idle).
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  int         m_busy_left = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_prev_wr = 1'b0;
  logic       m_wr_now, m_full_before, m_idle_before;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf       = 1'b0;
      m_busy_left = 0;
      m_byte      = 8'h00;
      m_prev_wr   = 1'b0;
    end else begin
      m_wr_now      = !iorq_n && !wr_n && m1_n;
      m_full_before = (mq.size() == DEPTH);
      m_idle_before = (m_busy_left == 0);
      if (m_busy_left > 0) m_busy_left--;
      if (m_idle_before && mq.size() > 0) begin
        m_byte      = mq.pop_front();
        m_busy_left = 10 * CPB;
      end
      if (m_wr_now && !m_prev_wr) begin
        if (io_addr == BASE) begin
          if (m_full_before) m_ovf = 1'b1;
          else mq.push_back(io_din);
        end else if (io_addr == CTRL && io_din[3]) begin
          m_ovf = 1'b0;
        end
      end
      m_prev_wr = m_wr_now;
    end
  end

  function automatic logic exp_tx();
    int elapsed, slot;
    if (m_busy_left == 0) return 1'b1;
    elapsed = 10 * CPB - m_busy_left;
    slot    = elapsed / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  function automatic logic [7:0] model_status();
    logic [2:0] c;
    c = 3'(mq.size());
    return {1'b0, c, m_ovf, (mq.size() == 0 && m_busy_left == 0),
            (mq.size() == 0), (mq.size() != DEPTH)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_cycle", tx, exp_tx());
      check("busy_cycle", tx_busy, (mq.size() != 0 || m_busy_left != 0));
    end
  end

  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold, input logic m1);
    @(negedge clk);
    io_addr = a; io_din = d; iorq_n = 1'b0; wr_n = 1'b0; m1_n = m1;
    repeat (hold) @(negedge clk);
    bus_idle();
  endtask

  task automatic io_read(input logic [7:0] a, input logic m1, output logic doe, output logic [7:0] dout);
    @(negedge clk);
    io_addr = a; iorq_n = 1'b0; rd_n = 1'b0; m1_n = m1;
    #1;
    doe  = io_doe;
    dout = io_dout;
    bus_idle();
  endtask

  task automatic check_status(input string name, input logic [7:0] exp);
    logic       doe;
    logic [7:0] d;
    io_read(CTRL, 1'b1, doe, d);
    check({name, "_doe"}, doe, 1'b1);
    check(name, d, exp);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, (n < budget), 1'b1);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic       iorq_n, rd_n, wr_n, m1_n;
    logic       exp_doe;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       doe;
    logic [7:0] d;
    logic [9:0] frame;
    logic       found;

    vecs[0] = '{CTRL,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07};
    vecs[1] = '{BASE,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{CTRL,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{CTRL,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{CTRL,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_doe", io_doe, 1'b0);
    check("rst_dout", io_dout, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Combinational decode, applied and removed within one low clock phase.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      io_addr = vecs[i].addr; iorq_n = vecs[i].iorq_n; rd_n = vecs[i].rd_n;
      wr_n = vecs[i].wr_n; m1_n = vecs[i].m1_n;
      #1;
      check($sformatf("vec%0d_doe", i), io_doe, vecs[i].exp_doe);
      check($sformatf("vec%0d_dout", i), io_dout, vecs[i].exp_dout);
      #1;
      bus_idle();
    end
    check_status("status_reset", 8'h07);

    // Single frame: tx idle for the FIFO-update cycle, then 10 bit slots.
    io_write(BASE, 8'h55, 1, 1'b1);
    check("f55_pre_tx", tx, 1'b1);
    check("f55_pre_busy", tx_busy, 1'b1);
    frame = {1'b1, 8'h55, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10 * CPB; i++) begin
      check($sformatf("f55_slot%0d", i / CPB), tx, frame[i / CPB]);
      @(negedge clk);
    end
    check("f55_end_busy", tx_busy, 1'b0);
    check_status("status_after_55", 8'h07);

    // Overflow: A0 pops, A1..A4 fill the FIFO, A5 is dropped.
    for (int i = 0; i < 6; i++) io_write(BASE, 8'hA0 + 8'(i), 1, 1'b1);
    check_status("status_ovf", 8'h48);
    io_write(CTRL, 8'h08, 1, 1'b1);
    check_status("status_ovf_clr", 8'h40);
    io_write(CTRL, 8'h00, 1, 1'b1);
    check_status("status_ctrl_nop", 8'h40);
    wait_idle("ovf", 600);
    check_status("status_ovf_drained", 8'h07);

    // Long write strobe pushes once; m1_n low writes and reads are ignored.
    io_write(BASE, 8'h3C, 1, 1'b1);
    io_write(BASE, 8'h5A, 10, 1'b1);
    check_status("status_hold", 8'h11);
    io_write(BASE, 8'h77, 10, 1'b0);
    check_status("status_m1_write", 8'h11);
    io_read(CTRL, 1'b0, doe, d);
    check("m1_read_doe", doe, 1'b0);
    check("m1_read_dout", d, 8'h00);
    wait_idle("hold", 300);

    // Reset during data bit 3 with two bytes still queued.
    io_write(BASE, 8'hF0, 1, 1'b1);
    io_write(BASE, 8'h11, 1, 1'b1);
    io_write(BASE, 8'h22, 1, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_busy_left == 10 * CPB - (4 * CPB + 1)) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_bit3", found, 1'b1);
    check("bit3_tx_low", tx, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_status("status_post_reset", 8'h07);
    repeat (60) @(negedge clk);
    check("post_reset_quiet", tx, 1'b1);
    check_status("status_post_reset_quiet", 8'h07);

    // Random bus traffic; the model checks tx and tx_busy every cycle.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 6))
        0, 1: io_write(BASE, 8'($urandom), $urandom_range(1, 3), 1'b1);
        2:    io_write(CTRL, 8'($urandom), $urandom_range(1, 2), 1'b1);
        3: begin
          io_read(CTRL, 1'b1, doe, d);
          check("rnd_doe", doe, 1'b1);
          check("rnd_status", d, model_status());
        end
        4:    repeat ($urandom_range(1, 30)) @(negedge clk);
        5:    io_write(BASE, 8'($urandom), $urandom_range(1, 3), 1'b0);
        default: io_write(8'h33, 8'($urandom), 1, 1'b1);
      endcase
    end
    wait_idle("random", 1000);
    io_read(CTRL, 1'b1, doe, d);
    check("final_status", d, model_status());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
